// File: rtl/conv_pe_stream.sv
// rtl/conv_pe_stream.sv - streaming mixed-precision conv PE with outlier budget
// Accumulates cfg_k beats of LANES act*wgt products into one saturating output word.
module conv_pe_stream #(
  parameter int DW     = 16,
  parameter int LANES  = 4,
  parameter int ACC_W  = 48,
  parameter int KB_MAX = 256,
  localparam int KW    = $clog2(KB_MAX) + 1,
  localparam int MW    = $clog2(LANES * KB_MAX) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [KW-1:0]       cfg_k,
  input  logic [DW-1:0]       cfg_thresh,
  input  logic [MW-1:0]       cfg_m,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_act,
  input  logic [LANES*DW-1:0] in_wgt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
  output logic [MW-1:0]       out_outliers,
  output logic                out_clamped,
  output logic                out_sat
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state, state_nxt;

  logic [KW-1:0]           k_q, cnt_q, k_use;
  logic [DW-1:0]           th_q, th_use;
  logic [MW-1:0]           m_q, m_use, ocnt_q, run;
  logic signed [ACC_W-1:0] acc_q, acc_nxt, beat_sum;
  logic signed [ACC_W:0]   wide;
  logic                    clamp_q, sat_q, beat_clamp, ovf, accept, last_beat, drop;

  logic signed [DW-1:0]    a, w, eff;
  logic [DW-1:0]           mag;
  logic signed [2*DW-1:0]  prod;

  assign in_ready     = !reset && (state != OUT);
  assign out_valid    = (state == OUT);
  assign out_data     = acc_q;
  assign out_outliers = ocnt_q;
  assign out_clamped  = clamp_q;
  assign out_sat      = sat_q;

  assign accept    = in_valid && in_ready && !clear;
  assign drop      = clear || (state == OUT && out_ready);

  // The first beat of an output uses live config; later beats use the latched copy.
  always_comb begin
    k_use  = k_q;
    th_use = th_q;
    m_use  = m_q;
    if (state == IDLE) begin
      k_use  = (cfg_k == '0) ? KW'(1) : cfg_k;
      th_use = cfg_thresh;
      m_use  = cfg_m;
    end
  end

  assign last_beat = accept && ((cnt_q + KW'(1)) == k_use);

  // Lanes are walked in ascending order so the budget is spent on the lowest lanes first.
  always_comb begin
    run        = ocnt_q;
    beat_clamp = 1'b0;
    beat_sum   = '0;
    a          = '0;
    w          = '0;
    mag        = '0;
    eff        = '0;
    prod       = '0;
    for (int i = 0; i < LANES; i++) begin
      a   = in_act[i*DW +: DW];
      w   = in_wgt[i*DW +: DW];
      mag = a[DW-1] ? -a : a;
      eff = a;
      if (mag > th_use) begin
        if (run >= m_use) begin
          eff        = a[DW-1] ? -$signed(th_use) : $signed(th_use);
          beat_clamp = 1'b1;
        end
        run = run + MW'(1);
      end
      prod     = eff * w;
      beat_sum = beat_sum + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    end
  end

  always_comb begin
    wide    = {acc_q[ACC_W-1], acc_q} + {beat_sum[ACC_W-1], beat_sum};
    ovf     = wide[ACC_W] ^ wide[ACC_W-1];
    acc_nxt = wide[ACC_W-1:0];
    if (ovf) acc_nxt = wide[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_beat ? OUT : ACCUM;
      ACCUM:   if (last_beat) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      k_q     <= '0;
      th_q    <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      ocnt_q  <= '0;
      acc_q   <= '0;
      clamp_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (drop) begin
        cnt_q   <= '0;
        ocnt_q  <= '0;
        acc_q   <= '0;
        clamp_q <= 1'b0;
        sat_q   <= 1'b0;
      end else if (accept) begin
        if (state == IDLE) begin
          k_q  <= k_use;
          th_q <= th_use;
          m_q  <= m_use;
        end
        cnt_q   <= cnt_q + KW'(1);
        ocnt_q  <= run;
        clamp_q <= clamp_q | beat_clamp;
        // Once saturated the accumulator stays pinned at its bound.
        if (!sat_q) begin
          acc_q <= acc_nxt;
          sat_q <= ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_pe_stream.sv
// tb/tb_conv_pe_stream.sv - directed self-checking bench for conv_pe_stream
// A second instance with ACC_W=34 shares all inputs to exercise saturation.
module tb_conv_pe_stream;
  localparam int DW = 16;
  localparam int KW = 9;
  localparam int MW = 11;

  logic          clk = 1'b0, reset = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [KW-1:0] cfg_k;
  logic [DW-1:0] cfg_thresh;
  logic [MW-1:0] cfg_m;
  logic [63:0]   in_act, in_wgt;
  logic          in_ready, out_valid, out_clamped, out_sat;
  logic [47:0]   out_data;
  logic [MW-1:0] out_outliers;
  logic          s_in_ready, s_out_valid, s_out_clamped, s_out_sat;
  logic [33:0]   s_out_data;
  logic [MW-1:0] s_out_outliers;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_pe_stream u_dut (
    .clk(clk), .reset(reset), .clear(clear), .cfg_k(cfg_k), .cfg_thresh(cfg_thresh),
    .cfg_m(cfg_m), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
    .in_wgt(in_wgt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_outliers(out_outliers), .out_clamped(out_clamped), .out_sat(out_sat)
  );

  conv_pe_stream #(.ACC_W(34)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .cfg_k(cfg_k), .cfg_thresh(cfg_thresh),
    .cfg_m(cfg_m), .in_valid(in_valid), .in_ready(s_in_ready), .in_act(in_act),
    .in_wgt(in_wgt), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_outliers(s_out_outliers), .out_clamped(s_out_clamped), .out_sat(s_out_sat)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic beat(input logic [63:0] a, input logic [63:0] w);
    in_act   = a;
    in_wgt   = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    cfg_k = 9'd2; cfg_thresh = 16'd100; cfg_m = '0;
    in_act = '0; in_wgt = '0;
    #12;
    check("rst_in_ready_held", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_outliers", out_outliers, 0);
    check("rst_clamped", out_clamped, 0);
    check("rst_sat", out_sat, 0);

    // basic dot product, k=2
    beat(pk(1, 2, 3, 4), pk(2, 2, 2, 2));
    check("dot_mid_valid", out_valid, 0);
    beat(pk(1, 2, 3, 4), pk(2, 2, 2, 2));
    check("dot_valid", out_valid, 1);
    check("dot_data", out_data, 40);
    check("dot_outliers", out_outliers, 0);
    check("dot_clamped", out_clamped, 0);
    check("dot_in_ready", in_ready, 0);
    consume();
    check("dot_done_valid", out_valid, 0);
    check("dot_done_ready", in_ready, 1);
    check("dot_done_data", out_data, 0);

    // budget m=1: lane0 full 50, lane1 clamped to -10
    cfg_k = 9'd1; cfg_thresh = 16'd10; cfg_m = 11'd1;
    beat(pk(50, -60, 5, 0), pk(1, 1, 1, 1));
    check("bud_valid", out_valid, 1);
    check("bud_data", out_data, 45);
    check("bud_outliers", out_outliers, 2);
    check("bud_clamped", out_clamped, 1);

    // backpressure with a pending beat, then cfg_k=0 treated as k=1
    cfg_k = 9'd0; cfg_thresh = 16'd100; cfg_m = '0;
    in_act = pk(1, 1, 1, 1); in_wgt = pk(3, 3, 3, 3); in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 45);
      check("bp_outliers", out_outliers, 2);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("k0_valid", out_valid, 1);
    check("k0_data", out_data, 12);
    consume();

    // k=3 with random gaps; cfg_k change mid-group is ignored
    cfg_k = 9'd3;
    for (int b = 0; b < 3; b++) begin
      beat(pk(10, 20, 30, 40), pk(1, 2, 3, 4));
      if (b == 0) cfg_k = 9'd1;
      if (b < 2) begin
        check("gap_mid_valid", out_valid, 0);
        idle($urandom_range(0, 3));
        check("gap_idle_valid", out_valid, 0);
      end
    end
    check("gap_valid", out_valid, 1);
    check("gap_data", out_data, 900);
    consume();

    // saturation on the ACC_W=34 instance; -32768 counts as outlier
    cfg_k = 9'd8; cfg_thresh = 16'd32767; cfg_m = 11'd1023;
    for (int b = 0; b < 8; b++) beat(pk(-32768, -32768, -32768, -32768), pk(-32768, -32768, -32768, -32768));
    check("sat_valid", s_out_valid, 1);
    check("sat_data", s_out_data, 64'h1_FFFF_FFFF);
    check("sat_flag", s_out_sat, 1);
    check("wide_data", out_data, 64'h8_0000_0000);
    check("wide_sat", out_sat, 0);
    check("wide_outliers", out_outliers, 32);
    check("wide_clamped", out_clamped, 0);
    consume();

    // clear after 3 of 5 beats, beat on clear cycle not accepted
    cfg_k = 9'd5; cfg_thresh = 16'd100; cfg_m = '0;
    for (int b = 0; b < 3; b++) beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    clear = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clr_data", out_data, 0);
    idle(3);
    check("clr_valid", out_valid, 0);
    cfg_k = 9'd1;
    beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    check("clr_next_valid", out_valid, 1);
    check("clr_next_data", out_data, 4);
    consume();

    // async reset mid-group
    cfg_k = 9'd5;
    beat(pk(200, 1, 1, 1), pk(1, 1, 1, 1));
    beat(pk(200, 1, 1, 1), pk(1, 1, 1, 1));
    #3 reset = 1'b1;
    #1;
    check("arst_data", out_data, 0);
    check("arst_outliers", out_outliers, 0);
    check("arst_clamped", out_clamped, 0);
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cfg_k = 9'd1;
    beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    check("arst_next_valid", out_valid, 1);
    check("arst_next_data", out_data, 4);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
